// File: rtl/switch_controller_if.sv
// switch_controller_if: raw switch inputs and conditioned clock-core controls
interface switch_controller_if;
  logic       sw_mode;
  logic       sw_start;
  logic       sw_reset;
  logic [1:0] mode;
  logic [1:0] select;
  logic       increment;
  logic       run;
  logic       clear;
  logic       alarm_enable;
  logic [2:0] sw_db;
  modport master (
    input  sw_mode, sw_start, sw_reset,
    output mode, select, increment, run, clear, alarm_enable, sw_db
  );
  modport slave (
    output sw_mode, sw_start, sw_reset,
    input  mode, select, increment, run, clear, alarm_enable, sw_db
  );
endinterface

// File: rtl/switch_controller.sv
// switch_controller: synchronizes, debounces and edge-detects the board switches and runs the mode/field FSM
module switch_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               global_reset,
  switch_controller_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {CLOCK, CLOCK_EDIT, ALARM_EDIT, STOPWATCH} mode_t;
  typedef enum logic [1:0] {NONE, SEC, MIN, HOUR} sel_t;
  logic [2:0] raw, s1, s2, stable, stable_d, rise;
  logic [2:1] fall;
  mode_t md;
  sel_t  sel;
  logic  inc, clr, al;
  assign raw = {bus.sw_reset, bus.sw_start, bus.sw_mode};
  always_ff @(posedge clk or posedge global_reset)
    if (global_reset) begin
      s1       <= '0;
      s2       <= '0;
      stable_d <= '0;
      rise     <= '0;
      fall     <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      rise     <= stable & ~stable_d;
      fall     <= ~stable[2:1] & stable_d[2:1];
    end
  // Each channel only accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing samples
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          st;
    always_ff @(posedge clk or posedge global_reset)
      if (global_reset) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (s2[i] == st) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        st  <= s2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    assign stable[i] = st;
  end
  // Mode rise wins and swallows any same-cycle start/reset events
  always_ff @(posedge clk or posedge global_reset)
    if (global_reset) begin
      md  <= CLOCK;
      sel <= NONE;
      inc <= 1'b0;
      clr <= 1'b0;
      al  <= 1'b0;
    end else begin
      inc <= 1'b0;
      clr <= 1'b0;
      if (rise[0]) begin
        md  <= mode_t'(md + 2'd1);
        sel <= (md == CLOCK || md == CLOCK_EDIT) ? SEC : NONE;
      end else begin
        case (md)
          CLOCK: if (|{rise[2:1], fall}) al <= stable[1] & stable[2];
          CLOCK_EDIT, ALARM_EDIT: begin
            if (rise[2]) sel <= (sel == HOUR) ? SEC : sel_t'(sel + 2'd1);
            inc <= rise[1];
          end
          STOPWATCH: clr <= rise[2];
          default: ;
        endcase
      end
    end
  assign bus.mode         = md;
  assign bus.select       = sel;
  assign bus.increment    = inc;
  assign bus.clear        = clr;
  assign bus.alarm_enable = al;
  assign bus.run          = (md == STOPWATCH) & stable[1];
  assign bus.sw_db        = stable;
endmodule

// File: tb/tb_switch_controller.sv
// tb_switch_controller: scoreboard bench; expected output events are queued when switches are driven
module tb_switch_controller;
  localparam int D = 4;
  localparam int LAT = D + 4;
  localparam int RLAT = D + 2;
  typedef struct { int cyc; logic [7:0] v; } exp_t;
  logic clk = 1'b0;
  logic global_reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int sel_seq [4] = '{2, 3, 1, 2};
  logic [7:0] prev = '0;
  exp_t q [$];
  switch_controller_if bus ();
  switch_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .global_reset(global_reset),
    .bus(bus)
  );
  wire [7:0] vec = {bus.mode, bus.select, bus.increment, bus.run, bus.clear, bus.alarm_enable};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic push(input int due, input int m, input int s, input bit inc, input bit run, input bit clr, input bit al);
    q.push_back('{due, {2'(m), 2'(s), inc, run, clr, al}});
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic mode_step(input int m, input int s, input bit al);
    bus.sw_mode = 1'b1;
    push(cyc + LAT, m, s, 0, 0, 0, al);
    idle(20);
    bus.sw_mode = 1'b0;
    idle(20);
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (!global_reset && vec !== prev) begin
      if (q.size() == 0) check("extra_event", 32'(vec), 32'(prev));
      else begin
        exp_t e;
        e = q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_value", 32'(vec), 32'(e.v));
      end
    end
    prev = vec;
  end
  initial begin
    bus.sw_mode = 1'b0;
    bus.sw_start = 1'b0;
    bus.sw_reset = 1'b0;
    idle(3);
    check("reset_state", 32'({bus.sw_db, vec}), 0);
    global_reset = 1'b0;
    for (int i = 1; i <= 4; i++) mode_step(i % 4, (i == 1 || i == 2) ? 1 : 0, 0);
    mode_step(1, 1, 0);
    bus.sw_start = 1'b1;
    idle(3);
    bus.sw_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      check("glitch_db", 32'(bus.sw_db[1]), 0);
    end
    bus.sw_start = 1'b1;
    push(cyc + LAT, 1, 1, 1, 0, 0, 0);
    push(cyc + LAT + 1, 1, 1, 0, 0, 0, 0);
    idle(10);
    bus.sw_start = 1'b0;
    idle(20);
    mode_step(2, 1, 0);
    for (int i = 0; i < 4; i++) begin
      bus.sw_reset = 1'b1;
      push(cyc + LAT, 2, sel_seq[i], 0, 0, 0, 0);
      idle(10);
      bus.sw_reset = 1'b0;
      idle(10);
    end
    mode_step(3, 0, 0);
    mode_step(0, 0, 0);
    bus.sw_start = 1'b1;
    bus.sw_reset = 1'b1;
    push(cyc + LAT, 0, 0, 0, 0, 0, 1);
    idle(20);
    bus.sw_reset = 1'b0;
    push(cyc + LAT, 0, 0, 0, 0, 0, 0);
    idle(20);
    bus.sw_reset = 1'b1;
    push(cyc + LAT, 0, 0, 0, 0, 0, 1);
    idle(20);
    mode_step(1, 1, 1);
    bus.sw_start = 1'b0;
    bus.sw_reset = 1'b0;
    idle(20);
    mode_step(2, 1, 1);
    mode_step(3, 0, 1);
    bus.sw_start = 1'b1;
    push(cyc + RLAT, 3, 0, 0, 1, 0, 1);
    idle(20);
    bus.sw_reset = 1'b1;
    push(cyc + LAT, 3, 0, 0, 1, 1, 1);
    push(cyc + LAT + 1, 3, 0, 0, 1, 0, 1);
    idle(20);
    bus.sw_reset = 1'b0;
    idle(20);
    mode_step(0, 0, 1);
    bus.sw_start = 1'b0;
    push(cyc + LAT, 0, 0, 0, 0, 0, 0);
    idle(20);
    mode_step(1, 1, 0);
    mode_step(2, 1, 0);
    for (int i = 0; i < 2; i++) begin
      bus.sw_reset = 1'b1;
      push(cyc + LAT, 2, sel_seq[i], 0, 0, 0, 0);
      idle(10);
      bus.sw_reset = 1'b0;
      idle(10);
    end
    check("pre_reset_mode_select", 32'({bus.mode, bus.select}), 32'({2'd2, 2'd3}));
    bus.sw_mode = 1'b1;
    idle(4);
    #2 global_reset = 1'b1;
    #1 check("async_reset", 32'({bus.sw_db, vec}), 0);
    idle(3);
    global_reset = 1'b0;
    push(cyc + LAT, 1, 1, 0, 0, 0, 0);
    idle(20);
    bus.sw_mode = 1'b0;
    idle(20);
    check("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
